// File: rtl/morse_tx.sv
// morse_tx: parametrised Morse letter transmitter with start/busy/done handshake.
// Optional build macro MORSE_TX_REPEAT_EN adds the repeat_en input ("repeat" is a
// reserved word in SystemVerilog), which replays the latched letter after each gap.
module morse_tx #(
   parameter int PATTERN_W = 16,
   parameter int LEN_W     = 5,
   parameter int SEL_W     = 3,
   parameter int TICK_DIV  = 25000000,
   parameter int GAP_UNITS = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [SEL_W-1:0] letter,
`ifdef MORSE_TX_REPEAT_EN
   input  logic             repeat_en,
`endif
   output logic             busy,
   output logic             done,
   output logic             out
);

   localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);
   localparam logic [LEN_W-1:0] GAP_L   = LEN_W'(GAP_UNITS);

   // LOAD separates acceptance from the first unit so busy/out start one cycle later.
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   state_t               state, state_nx;
   logic [PATTERN_W-1:0] shift_q, shift_nx;
   logic [LEN_W-1:0]     unit_q, unit_nx;
   logic [DIV_W-1:0]     div_q, div_nx;
   logic                 done_q, done_nx;
   logic                 tick;
`ifdef MORSE_TX_REPEAT_EN
   logic [SEL_W-1:0]     sel_q, sel_nx;
`endif

   // Raw table entry, pattern right-aligned in the low len bits.
   function automatic logic [31:0] raw_bits(input logic [SEL_W-1:0] code);
      case (32'(code))
         0:       return 32'b10101;
         1:       return 32'b111;
         2:       return 32'b1010111;
         3:       return 32'b101010111;
         4:       return 32'b101110111;
         5:       return 32'b11101010111;
         6:       return 32'b1110101110111;
         7:       return 32'b11101110101;
         default: return 32'b0;
      endcase
   endfunction

   function automatic int unsigned raw_len(input logic [SEL_W-1:0] code);
      case (32'(code))
         0:       return 5;
         1:       return 3;
         2:       return 7;
         3, 4:    return 9;
         5, 7:    return 11;
         6:       return 13;
         default: return 0;
      endcase
   endfunction

   // MSB-align the pattern; overlong entries keep only their first PATTERN_W units.
   function automatic logic [PATTERN_W-1:0] align(input logic [SEL_W-1:0] code);
      int unsigned len;
      len = raw_len(code);
      if (len > PATTERN_W) return PATTERN_W'(raw_bits(code) >> (len - PATTERN_W));
      else                 return PATTERN_W'(raw_bits(code)) << (PATTERN_W - len);
   endfunction

   function automatic logic [LEN_W-1:0] eff_len(input logic [SEL_W-1:0] code);
      int unsigned len;
      len = raw_len(code);
      return LEN_W'((len > PATTERN_W) ? PATTERN_W : len);
   endfunction

   assign tick = (div_q == '0);

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         shift_q <= '0;
         unit_q  <= '0;
         div_q   <= '0;
         done_q  <= 1'b0;
`ifdef MORSE_TX_REPEAT_EN
         sel_q   <= '0;
`endif
      end else begin
         state   <= state_nx;
         shift_q <= shift_nx;
         unit_q  <= unit_nx;
         div_q   <= div_nx;
         done_q  <= done_nx;
`ifdef MORSE_TX_REPEAT_EN
         sel_q   <= sel_nx;
`endif
      end
   end

   // Next-state, divider, shifter and unit counter logic.
   always_comb begin
      state_nx = state;
      shift_nx = shift_q;
      unit_nx  = unit_q;
      div_nx   = div_q;
      done_nx  = 1'b0;
`ifdef MORSE_TX_REPEAT_EN
      sel_nx   = sel_q;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               shift_nx = align(letter);
               unit_nx  = eff_len(letter);
               div_nx   = DIV_MAX;
               state_nx = LOAD;
`ifdef MORSE_TX_REPEAT_EN
               sel_nx   = letter;
`endif
            end
         end
         LOAD: begin
            if (unit_q == '0) begin
               unit_nx  = GAP_L;
               state_nx = GAP;
            end else begin
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            div_nx = tick ? DIV_MAX : div_q - 1'b1;
            if (tick) begin
               shift_nx = shift_q << 1;
               unit_nx  = unit_q - 1'b1;
               if (unit_q == LEN_W'(1)) begin
                  unit_nx  = GAP_L;
                  state_nx = GAP;
               end
            end
         end
         GAP: begin
            div_nx = tick ? DIV_MAX : div_q - 1'b1;
            if (tick) begin
               unit_nx = unit_q - 1'b1;
               if (unit_q == LEN_W'(1)) begin
                  done_nx  = 1'b1;
                  state_nx = IDLE;
`ifdef MORSE_TX_REPEAT_EN
                  if (repeat_en) begin
                     shift_nx = align(sel_q);
                     unit_nx  = eff_len(sel_q);
                     state_nx = SHIFT;
                     if (eff_len(sel_q) == '0) begin
                        unit_nx  = GAP_L;
                        state_nx = GAP;
                     end
                  end
`endif
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign out  = (state == SHIFT) && shift_q[PATTERN_W-1];
   assign busy = (state == SHIFT) || (state == GAP);
   assign done = done_q;

endmodule
